// File: rtl/operand_entry.sv
// Keypad operand assembler: turns debounced key codes into two signed operands
// for the multiplier, with sign entry, saturation and a one-cycle valid pulse.
module operand_entry #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] numero1_o,
  output logic [WIDTH-1:0] numero2_o,
  output logic             valid,
  output logic [9:0]       entry_mag,
  output logic             entry_sign,
  output logic [1:0]       entry_state,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(DIGITS + 1);

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam logic [9:0] POS_LIM = 10'((1 << (WIDTH - 1)) - 1);
  localparam logic [9:0] NEG_LIM = 10'(1 << (WIDTH - 1));

  typedef enum logic [1:0] {
    A_ENTRY = 2'd0,
    B_ENTRY = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t          state_q;
  logic            kv_q, kv_qq, rise_q;
  logic [3:0]      code_q, cmd_q;
  logic [9:0]      mag_q;
  logic            sign_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] n1_q, n2_q;
  logic            valid_q, ovf_q;

  logic [13:0]      acc_d;
  logic [9:0]       neg_d;
  logic [WIDTH-1:0] conv_d;
  logic             sat_d;
  logic             room_d;

  always_comb begin
    acc_d  = 14'(mag_q) * 14'd10 + 14'(cmd_q);
    neg_d  = 10'd0 - mag_q;
    room_d = (32'(cnt_q) < DIGITS);
    conv_d = '0;
    sat_d  = 1'b0;
    // Negative zero falls out naturally: 0 - 0 is 0.
    if (!sign_q) begin
      if (mag_q <= POS_LIM) begin
        conv_d = mag_q[WIDTH-1:0];
      end else begin
        conv_d = {1'b0, {(WIDTH-1){1'b1}}};
        sat_d  = 1'b1;
      end
    end else begin
      if (mag_q <= NEG_LIM) begin
        conv_d = neg_d[WIDTH-1:0];
      end else begin
        conv_d = {1'b1, {(WIDTH-1){1'b0}}};
        sat_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kv_q    <= 1'b0;
      kv_qq   <= 1'b0;
      rise_q  <= 1'b0;
      code_q  <= '0;
      cmd_q   <= '0;
      state_q <= A_ENTRY;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // Two-stage key pipeline: code travels alongside the registered edge.
      kv_q    <= key_valid;
      kv_qq   <= kv_q;
      code_q  <= key_code;
      rise_q  <= kv_q & ~kv_qq;
      cmd_q   <= code_q;
      valid_q <= 1'b0;
      if (rise_q) begin
        if (cmd_q == KEY_CLEAR) begin
          state_q <= A_ENTRY;
          mag_q   <= '0;
          sign_q  <= 1'b0;
          cnt_q   <= '0;
          n1_q    <= '0;
          n2_q    <= '0;
          ovf_q   <= 1'b0;
        end else if (cmd_q <= 4'd9) begin
          if (state_q == HOLD) begin
            state_q <= A_ENTRY;
            ovf_q   <= 1'b0;
            mag_q   <= 10'(cmd_q);
            sign_q  <= 1'b0;
            cnt_q   <= CW'(1);
          end else if (room_d) begin
            mag_q <= acc_d[9:0];
            cnt_q <= cnt_q + CW'(1);
          end
        end else if (cmd_q == KEY_SIGN) begin
          if (state_q == HOLD) begin
            state_q <= A_ENTRY;
            mag_q   <= '0;
            sign_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            sign_q <= ~sign_q;
          end
        end else if (cmd_q == KEY_ENTER) begin
          case (state_q)
            A_ENTRY: begin
              n1_q    <= conv_d;
              ovf_q   <= ovf_q | sat_d;
              mag_q   <= '0;
              sign_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= B_ENTRY;
            end
            B_ENTRY: begin
              n2_q    <= conv_d;
              ovf_q   <= ovf_q | sat_d;
              mag_q   <= '0;
              sign_q  <= 1'b0;
              cnt_q   <= '0;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
            HOLD:    valid_q <= 1'b1;
            default: state_q <= A_ENTRY;
          endcase
        end
      end
    end
  end

  assign numero1_o   = n1_q;
  assign numero2_o   = n2_q;
  assign valid       = valid_q;
  assign entry_mag   = mag_q;
  assign entry_sign  = sign_q;
  assign entry_state = state_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed keypad sequences plus random key streams
// checked against an arithmetic model of the operand entry rules.
module tb_operand_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [7:0] numero1_o, numero2_o;
  logic       valid;
  logic [9:0] entry_mag;
  logic       entry_sign;
  logic [1:0] entry_state;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int viol   = 0;

  int         m_state, m_mag, m_cnt, m_vexp;
  bit         m_sign, m_ovf;
  logic [7:0] m_n1, m_n2;

  operand_entry #(.DIGITS(3), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .numero1_o(numero1_o), .numero2_o(numero2_o), .valid(valid),
    .entry_mag(entry_mag), .entry_sign(entry_sign), .entry_state(entry_state),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      if (entry_state !== 2'd2) viol++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic model_reset();
    m_state = 0; m_mag = 0; m_cnt = 0; m_sign = 0; m_ovf = 0;
    m_n1 = 8'h00; m_n2 = 8'h00;
  endtask

  task automatic model_key(input logic [3:0] c);
    int v;
    if (c == 4'hC) begin
      model_reset();
    end else if (c <= 4'd9) begin
      if (m_state == 2) begin
        m_ovf = 0; m_state = 0; m_mag = int'(c); m_cnt = 1; m_sign = 0;
      end else if (m_cnt < 3) begin
        m_mag = m_mag * 10 + int'(c); m_cnt++;
      end
    end else if (c == 4'hA) begin
      if (m_state == 2) begin
        m_state = 0; m_mag = 0; m_cnt = 0; m_sign = 1;
      end else begin
        m_sign = !m_sign;
      end
    end else if (c == 4'hB) begin
      if (m_state == 2) begin
        m_vexp++;
      end else begin
        if (!m_sign) begin
          if (m_mag > 127) begin v = 127; m_ovf = 1; end else v = m_mag;
        end else begin
          if (m_mag > 128) begin v = -128; m_ovf = 1; end else v = -m_mag;
        end
        if (m_state == 0) begin
          m_n1 = 8'(v); m_state = 1;
        end else begin
          m_n2 = 8'(v); m_state = 2; m_vexp++;
        end
        m_mag = 0; m_cnt = 0; m_sign = 0;
      end
    end
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int gap);
    @(negedge clk);
    key_code  = c;
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    repeat (gap) @(negedge clk);
    model_key(c);
  endtask

  task automatic key(input logic [3:0] c);
    press(c, 1, 3);
  endtask

  task automatic test_reset();
    if (numero1_o !== 8'h00) begin bad++; $display("FAIL rst_n1 got %h exp 00", numero1_o); end
    total++;
    if (numero2_o !== 8'h00) begin bad++; $display("FAIL rst_n2 got %h exp 00", numero2_o); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b exp 0", valid); end
    total++;
    if (entry_mag !== 10'd0) begin bad++; $display("FAIL rst_mag got %0d exp 0", entry_mag); end
    total++;
    if (entry_sign !== 1'b0) begin bad++; $display("FAIL rst_sign got %b exp 0", entry_sign); end
    total++;
    if (entry_state !== 2'd0) begin bad++; $display("FAIL rst_state got %0d exp 0", entry_state); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    total++;
  endtask

  task automatic test_latency();
    key(4'hC);
    @(negedge clk);
    key_code = 4'h5; key_valid = 1'b1;
    @(negedge clk);
    if (entry_mag !== 10'd0) begin bad++; $display("FAIL lat_n got %0d exp 0", entry_mag); end
    total++;
    @(negedge clk);
    key_valid = 1'b0;
    if (entry_mag !== 10'd0) begin bad++; $display("FAIL lat_n1 got %0d exp 0", entry_mag); end
    total++;
    @(negedge clk);
    if (entry_mag !== 10'd5) begin bad++; $display("FAIL lat_n2 got %0d exp 5", entry_mag); end
    total++;
    model_key(4'h5);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_two_operands();
    int v0;
    key(4'hC);
    v0 = vcount;
    key(4'h1); key(4'h2); key(4'h3); key(4'hB);
    key(4'hA); key(4'h4); key(4'h5); key(4'hB);
    if (numero1_o !== 8'h7B) begin bad++; $display("FAIL two_n1 got %h exp 7b", numero1_o); end
    total++;
    if (numero2_o !== 8'hD3) begin bad++; $display("FAIL two_n2 got %h exp d3", numero2_o); end
    total++;
    if (vcount - v0 !== 1) begin bad++; $display("FAIL two_valid got %0d pulses exp 1", vcount - v0); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL two_ovf got %b exp 0", overflow); end
    total++;
    if (entry_state !== 2'd2) begin bad++; $display("FAIL two_state got %0d exp 2", entry_state); end
    total++;
  endtask

  task automatic test_saturation();
    key(4'hC); key(4'h2); key(4'h0); key(4'h0); key(4'hB);
    if (numero1_o !== 8'h7F) begin bad++; $display("FAIL sat_pos got %h exp 7f", numero1_o); end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL sat_pos_ovf got %b exp 1", overflow); end
    total++;
    key(4'hC); key(4'hA); key(4'h1); key(4'h2); key(4'h8); key(4'hB);
    if (numero1_o !== 8'h80) begin bad++; $display("FAIL sat_m128 got %h exp 80", numero1_o); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL sat_m128_ovf got %b exp 0", overflow); end
    total++;
    key(4'hC); key(4'hA); key(4'h1); key(4'h2); key(4'h9); key(4'hB);
    if (numero1_o !== 8'h80) begin bad++; $display("FAIL sat_m129 got %h exp 80", numero1_o); end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL sat_m129_ovf got %b exp 1", overflow); end
    total++;
  endtask

  task automatic test_digit_limit();
    key(4'hC); key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    if (entry_mag !== 10'd123) begin bad++; $display("FAIL lim_mag got %0d exp 123", entry_mag); end
    total++;
    key(4'hC);
    press(4'h7, 5, 3);
    if (entry_mag !== 10'd7) begin bad++; $display("FAIL held_mag got %0d exp 7", entry_mag); end
    total++;
  endtask

  task automatic test_hold();
    int v0;
    key(4'hC); key(4'h2); key(4'h0); key(4'h0); key(4'hB); key(4'h3); key(4'hB);
    v0 = vcount;
    key(4'hB);
    if (vcount - v0 !== 1) begin bad++; $display("FAIL hold_repulse got %0d pulses exp 1", vcount - v0); end
    total++;
    if (numero1_o !== 8'h7F || numero2_o !== 8'h03) begin
      bad++; $display("FAIL hold_ops got %h/%h exp 7f/03", numero1_o, numero2_o);
    end
    total++;
    key(4'h9);
    if (entry_state !== 2'd0) begin bad++; $display("FAIL hold_dig_state got %0d exp 0", entry_state); end
    total++;
    if (entry_mag !== 10'd9) begin bad++; $display("FAIL hold_dig_mag got %0d exp 9", entry_mag); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL hold_dig_ovf got %b exp 0", overflow); end
    total++;
  endtask

  task automatic test_clear();
    key(4'hC); key(4'h1); key(4'hB); key(4'h5); key(4'h6);
    if (entry_state !== 2'd1 || entry_mag !== 10'd56) begin
      bad++; $display("FAIL clr_pre got state %0d mag %0d exp 1/56", entry_state, entry_mag);
    end
    total++;
    key(4'hC);
    if ({numero1_o, numero2_o, entry_mag, entry_sign, entry_state, overflow} !== '0) begin
      bad++; $display("FAIL clr_all got n1 %h n2 %h mag %0d st %0d ovf %b exp zeros",
                      numero1_o, numero2_o, entry_mag, entry_state, overflow);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    int v0;
    key(4'hC); key(4'h1); key(4'hB); key(4'h4); key(4'h5);
    v0 = vcount;
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    if ({numero1_o, numero2_o, valid, entry_mag, entry_sign, entry_state, overflow} !== '0) begin
      bad++; $display("FAIL rstmid_async got n1 %h mag %0d st %0d exp zeros", numero1_o, entry_mag, entry_state);
    end
    total++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    if (vcount !== v0) begin bad++; $display("FAIL rstmid_valid got %0d pulses exp 0", vcount - v0); end
    total++;
    if (entry_state !== 2'd0 || numero1_o !== 8'h00) begin
      bad++; $display("FAIL rstmid_after got st %0d n1 %h exp 0/00", entry_state, numero1_o);
    end
    total++;
  endtask

  task automatic test_ignored();
    int v0;
    key(4'hC); key(4'h3); key(4'hD); key(4'hE); key(4'hF);
    if (entry_mag !== 10'd3 || entry_state !== 2'd0 || entry_sign !== 1'b0) begin
      bad++; $display("FAIL ign_nochange got mag %0d st %0d sign %b exp 3/0/0", entry_mag, entry_state, entry_sign);
    end
    total++;
    key(4'h4);
    if (entry_mag !== 10'd34) begin bad++; $display("FAIL ign_count got %0d exp 34", entry_mag); end
    total++;
    key(4'hC);
    v0 = vcount;
    key(4'hB); key(4'hB);
    if (numero1_o !== 8'h00 || numero2_o !== 8'h00) begin
      bad++; $display("FAIL empty_ops got %h/%h exp 00/00", numero1_o, numero2_o);
    end
    total++;
    if (vcount - v0 !== 1) begin bad++; $display("FAIL empty_valid got %0d pulses exp 1", vcount - v0); end
    total++;
  endtask

  task automatic test_back_to_back();
    int v0;
    key(4'hC);
    v0 = vcount;
    press(4'h1, 1, 1); press(4'hB, 1, 1); press(4'h2, 1, 1); press(4'hB, 1, 1);
    press(4'hB, 1, 1); press(4'hB, 1, 1); press(4'h3, 1, 1);
    repeat (4) @(negedge clk);
    if (vcount - v0 !== 3) begin bad++; $display("FAIL b2b_valid got %0d pulses exp 3", vcount - v0); end
    total++;
    if (numero1_o !== 8'h01 || numero2_o !== 8'h02) begin
      bad++; $display("FAIL b2b_ops got %h/%h exp 01/02", numero1_o, numero2_o);
    end
    total++;
    if (entry_state !== 2'd0 || entry_mag !== 10'd3) begin
      bad++; $display("FAIL b2b_final got st %0d mag %0d exp 0/3", entry_state, entry_mag);
    end
    total++;
  endtask

  task automatic test_random();
    logic [3:0] c;
    int r;
    key(4'hC);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      c = 4'($urandom_range(0, 9));
      else if (r < 70) c = 4'hA;
      else if (r < 85) c = 4'hB;
      else if (r < 92) c = 4'hC;
      else             c = 4'($urandom_range(13, 15));
      press(c, $urandom_range(1, 4), 3);
      if (entry_mag !== 10'(m_mag)) begin bad++; $display("FAIL rnd_mag step %0d got %0d exp %0d", i, entry_mag, m_mag); end
      total++;
      if (entry_sign !== m_sign) begin bad++; $display("FAIL rnd_sign step %0d got %b exp %b", i, entry_sign, m_sign); end
      total++;
      if (entry_state !== 2'(m_state)) begin bad++; $display("FAIL rnd_state step %0d got %0d exp %0d", i, entry_state, m_state); end
      total++;
      if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf step %0d got %b exp %b", i, overflow, m_ovf); end
      total++;
      if (numero1_o !== m_n1) begin bad++; $display("FAIL rnd_n1 step %0d got %h exp %h", i, numero1_o, m_n1); end
      total++;
      if (numero2_o !== m_n2) begin bad++; $display("FAIL rnd_n2 step %0d got %h exp %h", i, numero2_o, m_n2); end
      total++;
      if (vcount !== m_vexp) begin bad++; $display("FAIL rnd_valid step %0d got %0d pulses exp %0d", i, vcount, m_vexp); end
      total++;
    end
    if (viol !== 0) begin bad++; $display("FAIL valid_outside_hold got %0d exp 0", viol); end
    total++;
  endtask

  initial begin
    model_reset();
    m_vexp = 0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_latency();
    test_two_operands();
    test_saturation();
    test_digit_limit();
    test_hold();
    test_clear();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    m_vexp = vcount;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
